c4_cursor_ctrl: RTL and testbench

Consumer end of the pushbutton debouncer interface for the connect-four game. Takes the single-cycle (SCEN) and multi-cycle autorepeat (MCEN) enables from the left, right and drop debouncers. Maintains the selected column and the current player. Issues a drop request to the board logic with a req/ack handshake.

---
 rtl/c4_pkg.sv | 16 +
 rtl/c4_cursor_ctrl_if.sv | 27 ++
 rtl/c4_col_wrap_ctr.sv | 28 ++
 rtl/c4_cursor_ctrl.sv | 101 ++++++++++
 tb/tb_c4_cursor_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/c4_pkg.sv
// Shared types and defaults for the connect-four cursor/drop controller.
package c4_pkg;

    localparam int unsigned C4_NUM_COLS  = 7;
    localparam int unsigned C4_COL_W     = 3;
    localparam int unsigned C4_START_COL = 3;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } c4_state_t;

endpackage

// File: rtl/c4_cursor_ctrl_if.sv
// Debouncer enables in, board drop handshake and cursor status out.
interface c4_cursor_ctrl_if #(
    parameter int unsigned COL_W = 3
);
    logic             L_SCEN;
    logic             L_MCEN;
    logic             R_SCEN;
    logic             R_MCEN;
    logic             D_SCEN;
    logic             DROP_ACK;
    logic             DROP_OK;
    logic [COL_W-1:0] COL;
    logic             DROP_REQ;
    logic [COL_W-1:0] DROP_COL;
    logic             PLAYER;
    logic             REJECT;

    modport master (
        output L_SCEN, L_MCEN, R_SCEN, R_MCEN, D_SCEN, DROP_ACK, DROP_OK,
        input  COL, DROP_REQ, DROP_COL, PLAYER, REJECT
    );

    modport slave (
        input  L_SCEN, L_MCEN, R_SCEN, R_MCEN, D_SCEN, DROP_ACK, DROP_OK,
        output COL, DROP_REQ, DROP_COL, PLAYER, REJECT
    );
endinterface

// File: rtl/c4_col_wrap_ctr.sv
// Up/down modulo-NUM_COLS column counter; reset loads START_COL.
module c4_col_wrap_ctr #(
    parameter int unsigned NUM_COLS  = 7,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned START_COL = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [COL_W-1:0] o_col
);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    logic [COL_W-1:0] r_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col <= COL_W'(START_COL);
        end else if (i_inc && !i_dec) begin
            r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
        end else if (i_dec && !i_inc) begin
            r_col <= (r_col == '0) ? LAST_COL : r_col - COL_W'(1);
        end
    end

    assign o_col = r_col;
endmodule

// File: rtl/c4_cursor_ctrl.sv
// Cursor column, player turn and drop req/ack handshake for connect-four.
// Define C4_AUTOREPEAT_EN to let the MCEN autorepeat enables move the cursor.
module c4_cursor_ctrl
    import c4_pkg::*;
#(
    parameter int unsigned NUM_COLS  = C4_NUM_COLS,
    parameter int unsigned COL_W     = C4_COL_W,
    parameter int unsigned START_COL = C4_START_COL
) (
    input  logic             CLK,
    input  logic             RESET,
    c4_cursor_ctrl_if.slave  bus
);
    c4_state_t        r_state, w_state_nxt;
    logic             r_drop_req, w_drop_req_nxt;
    logic [COL_W-1:0] r_drop_col, w_drop_col_nxt;
    logic             r_player, w_player_nxt;
    logic             r_reject, w_reject_nxt;
    logic             w_left_ev, w_right_ev;
    logic             w_inc, w_dec;
    logic [COL_W-1:0] w_col;

`ifdef C4_AUTOREPEAT_EN
    assign w_left_ev  = bus.L_SCEN | bus.L_MCEN;
    assign w_right_ev = bus.R_SCEN | bus.R_MCEN;
`else
    logic w_unused_mcen;
    assign w_left_ev     = bus.L_SCEN;
    assign w_right_ev    = bus.R_SCEN;
    assign w_unused_mcen = bus.L_MCEN | bus.R_MCEN;
`endif

    c4_col_wrap_ctr #(
        .NUM_COLS  (NUM_COLS),
        .COL_W     (COL_W),
        .START_COL (START_COL)
    ) u_col_ctr (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_inc (w_inc),
        .i_dec (w_dec),
        .o_col (w_col)
    );

    // Next-state and output decode; moves only in IDLE and lose to a drop.
    always_comb begin
        w_state_nxt    = r_state;
        w_drop_req_nxt = r_drop_req;
        w_drop_col_nxt = r_drop_col;
        w_player_nxt   = r_player;
        w_reject_nxt   = 1'b0;
        w_inc          = 1'b0;
        w_dec          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.D_SCEN) begin
                    w_drop_col_nxt = w_col;
                    w_drop_req_nxt = 1'b1;
                    w_state_nxt    = REQ;
                end else begin
                    w_inc = w_right_ev & ~w_left_ev;
                    w_dec = w_left_ev & ~w_right_ev;
                end
            end
            REQ: begin
                if (bus.DROP_ACK) begin
                    w_drop_req_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                    if (bus.DROP_OK) begin
                        w_player_nxt = (r_player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_drop_req <= 1'b0;
            r_drop_col <= '0;
            r_player   <= PLAYER_1;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_req <= w_drop_req_nxt;
            r_drop_col <= w_drop_col_nxt;
            r_player   <= w_player_nxt;
            r_reject   <= w_reject_nxt;
        end
    end

    assign bus.COL      = w_col;
    assign bus.DROP_REQ = r_drop_req;
    assign bus.DROP_COL = r_drop_col;
    assign bus.PLAYER   = r_player;
    assign bus.REJECT   = r_reject;
endmodule

// File: tb/tb_c4_cursor_ctrl.sv
// Directed bench for c4_cursor_ctrl; expectations follow C4_AUTOREPEAT_EN if defined.
module tb_c4_cursor_ctrl;
    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_fail;

    c4_cursor_ctrl_if #(.COL_W(3)) bus ();

    c4_cursor_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.L_SCEN   = 1'b0;
        bus.L_MCEN   = 1'b0;
        bus.R_SCEN   = 1'b0;
        bus.R_MCEN   = 1'b0;
        bus.D_SCEN   = 1'b0;
        bus.DROP_ACK = 1'b0;
        bus.DROP_OK  = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_l();
        bus.L_SCEN = 1'b1; tick(); clr();
    endtask

    task automatic pulse_r();
        bus.R_SCEN = 1'b1; tick(); clr();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clr();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_col", int'(bus.COL), 3);
        chk("rst_req", int'(bus.DROP_REQ), 0);
        chk("rst_dcol", int'(bus.DROP_COL), 0);
        chk("rst_player", int'(bus.PLAYER), 0);
        chk("rst_reject", int'(bus.REJECT), 0);

        pulse_l(); chk("left1", int'(bus.COL), 2);
        pulse_l(); chk("left2", int'(bus.COL), 1);
        pulse_l(); chk("left3", int'(bus.COL), 0);
        pulse_l(); chk("left_wrap", int'(bus.COL), 6);
        pulse_r(); chk("right_wrap", int'(bus.COL), 0);

        pulse_r(); pulse_r(); pulse_r();
        chk("right_to3", int'(bus.COL), 3);
        bus.L_SCEN = 1'b1; bus.R_SCEN = 1'b1; tick(); clr();
        chk("both_hold", int'(bus.COL), 3);

        pulse_r(); pulse_r();
        chk("right_to5", int'(bus.COL), 5);
        bus.D_SCEN = 1'b1; bus.R_SCEN = 1'b1; tick(); clr();
        chk("drop_req", int'(bus.DROP_REQ), 1);
        chk("drop_col", int'(bus.DROP_COL), 5);
        chk("drop_mv_discard", int'(bus.COL), 5);
        tick(); tick();
        chk("req_held", int'(bus.DROP_REQ), 1);
        bus.DROP_ACK = 1'b1; bus.DROP_OK = 1'b1; tick(); clr();
        chk("ack_ok_req", int'(bus.DROP_REQ), 0);
        chk("ack_ok_player", int'(bus.PLAYER), 1);
        chk("ack_ok_reject", int'(bus.REJECT), 0);

        bus.D_SCEN = 1'b1; tick(); clr();
        chk("drop2_req", int'(bus.DROP_REQ), 1);
        pulse_l(); pulse_r();
        bus.D_SCEN = 1'b1; tick(); clr();
        chk("req_col_frozen", int'(bus.COL), 5);
        chk("req_dcol_frozen", int'(bus.DROP_COL), 5);
        chk("req_still", int'(bus.DROP_REQ), 1);
        bus.DROP_ACK = 1'b1; bus.DROP_OK = 1'b0; tick(); clr();
        chk("nak_req", int'(bus.DROP_REQ), 0);
        chk("nak_reject", int'(bus.REJECT), 1);
        chk("nak_player", int'(bus.PLAYER), 1);
        tick();
        chk("reject_1cyc", int'(bus.REJECT), 0);
        chk("no_second_req", int'(bus.DROP_REQ), 0);

        bus.DROP_ACK = 1'b1; bus.DROP_OK = 1'b1; tick(); clr();
        chk("idle_ack_player", int'(bus.PLAYER), 1);
        chk("idle_ack_req", int'(bus.DROP_REQ), 0);

        bus.D_SCEN = 1'b1; tick(); clr();
        chk("drop3_req", int'(bus.DROP_REQ), 1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("rst_req_abandon", int'(bus.DROP_REQ), 0);
        chk("rst_req_col", int'(bus.COL), 3);
        chk("rst_req_player", int'(bus.PLAYER), 0);
        chk("rst_req_dcol", int'(bus.DROP_COL), 0);
        bus.DROP_ACK = 1'b1; bus.DROP_OK = 1'b1; tick(); clr();
        chk("late_ack_player", int'(bus.PLAYER), 0);
        chk("late_ack_req", int'(bus.DROP_REQ), 0);

        // Ack in the first request cycle, then a move on the very next edge.
        bus.D_SCEN = 1'b1; tick(); clr();
        bus.DROP_ACK = 1'b1; bus.DROP_OK = 1'b1; tick(); clr();
        chk("fast_ack_req", int'(bus.DROP_REQ), 0);
        chk("fast_ack_player", int'(bus.PLAYER), 1);
        pulse_l();
        chk("move_after_ack", int'(bus.COL), 2);
        pulse_r();
        chk("back_to3", int'(bus.COL), 3);

        for (int i = 0; i < 3; i++) begin
            bus.L_MCEN = 1'b1; tick(); clr();
        end
`ifdef C4_AUTOREPEAT_EN
        chk("mcen_steps", int'(bus.COL), 0);
        bus.L_SCEN = 1'b1; bus.L_MCEN = 1'b1; tick(); clr();
        chk("scen_mcen_single", int'(bus.COL), 6);
`else
        chk("mcen_ignored", int'(bus.COL), 3);
        bus.L_SCEN = 1'b1; bus.L_MCEN = 1'b1; tick(); clr();
        chk("scen_mcen_single", int'(bus.COL), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
